// File: rtl/dmem_access_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_seq_if
// Brief    : Pipeline request, memory bus and result signals of the data-memory
//            access sequencer, bundled with sequencer/environment modports.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_access_seq_if #(
    parameter int XLEN = 32
);
    logic            halt;
    logic            valid_in;
    logic [6:0]      opcode_in;
    logic [2:0]      funct3_in;
    logic [XLEN-1:0] addr_in;
    logic [XLEN-1:0] wdata_in;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ack;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] rdata_out;
    logic            done;
    logic            err;
    logic            stall;

    // master: the sequencer itself (drives the memory bus and results)
    modport master (
        input  halt, valid_in, opcode_in, funct3_in, addr_in, wdata_in,
               mem_ack, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               rdata_out, done, err, stall
    );

    // slave: pipeline plus memory side
    modport slave (
        output halt, valid_in, opcode_in, funct3_in, addr_in, wdata_in,
               mem_ack, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               rdata_out, done, err, stall
    );
endinterface
`default_nettype wire

// File: rtl/dmem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_seq
// Brief    : Load/store sequencer: one bus transaction per accepted request,
//            with alignment checks, lane steering and a wait-cycle timeout.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_seq #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_access_seq_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [6:0] c_op_load      = 7'b0000011;
    localparam logic [6:0] c_op_store     = 7'b0100011;
    localparam logic [3:0] c_timeout_last = 4'(TIMEOUT - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_is_store;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_rdata;
    logic [3:0]      r_cnt;

    logic            w_is_load;
    logic            w_is_store;
    logic            w_accept;
    logic            w_aligned;
    logic            w_legal;
    logic            w_busy;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_load_fmt;

    // Request decode works on the live inputs: legality is decided on the
    // accepting edge, before anything is latched.
    always_comb begin
        w_is_load  = (bus.opcode_in == c_op_load);
        w_is_store = (bus.opcode_in == c_op_store);
        w_accept   = (r_state == IDLE) && bus.valid_in && !bus.halt &&
                     (w_is_load || w_is_store);
        case (bus.funct3_in[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = !bus.addr_in[0];
            2'b10:   w_aligned = (bus.addr_in[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
        if (w_is_store)
            w_legal = !bus.funct3_in[2] && (bus.funct3_in[1:0] != 2'b11);
        else
            w_legal = (bus.funct3_in[1:0] != 2'b11) && (bus.funct3_in != 3'b110);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_state_next = (w_legal && w_aligned) ? BUSY : ERR;
            end
            BUSY: begin
                if (bus.mem_ack)
                    w_state_next = DONE;
                else if (r_cnt == c_timeout_last)
                    w_state_next = ERR;
            end
            DONE:    w_state_next = IDLE;
            ERR:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_store <= 1'b0;
            r_funct3   <= 3'b000;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= 4'd0;
        end else begin
            r_cnt <= (r_state == BUSY) ? r_cnt + 4'd1 : 4'd0;
            if (w_accept) begin
                r_is_store <= w_is_store;
                r_funct3   <= bus.funct3_in;
                r_addr     <= bus.addr_in;
                r_wdata    <= bus.wdata_in;
            end
            // Result holds until the next completion; stores and errors clear it.
            if (r_state == BUSY && bus.mem_ack)
                r_rdata <= r_is_store ? '0 : w_load_fmt;
            else if (w_state_next == ERR)
                r_rdata <= '0;
        end
    end

    always_comb begin
        case (r_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_wdata = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {r_addr[1], 1'b0};
                w_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = r_wdata;
            end
        endcase
        w_lane = bus.mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'b000:  w_load_fmt = {{(XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_load_fmt = {{(XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_load_fmt = {{(XLEN-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_load_fmt = {{(XLEN-16){1'b0}}, w_lane[15:0]};
            default: w_load_fmt = bus.mem_rdata;
        endcase
    end

    // Bus outputs are gated by state so they fall to zero as soon as the
    // state register is reset, with no clock needed.
    always_comb begin
        w_busy        = (r_state == BUSY);
        bus.mem_req   = w_busy;
        bus.mem_we    = w_busy && r_is_store;
        bus.mem_addr  = w_busy ? {r_addr[XLEN-1:2], 2'b00} : '0;
        bus.mem_be    = w_busy ? w_be : 4'b0000;
        bus.mem_wdata = (w_busy && r_is_store) ? w_wdata : '0;
        bus.rdata_out = r_rdata;
        bus.done      = (r_state == DONE);
        bus.err       = (r_state == ERR);
        bus.stall     = w_busy || w_accept;
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_access_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_seq
// Brief    : Scenario-driven bench for dmem_access_seq with an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_seq;
    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_alu   = 7'b0110011;

    typedef struct packed {
        logic        is_err;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dmem_access_seq_if #(.XLEN(32)) bus();

    dmem_access_seq #(.XLEN(32), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic exp_t mk(input logic is_err, input logic we, input logic [31:0] addr,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input logic [31:0] rdata);
        exp_t e;
        e.is_err = is_err; e.we = we; e.addr = addr; e.be = be; e.wdata = wdata; e.rdata = rdata;
        return e;
    endfunction

    // Issue one request, serve the bus (ack in the ack_at-th busy cycle, 0 = never)
    // and check the completion against the queued expectation.
    task automatic do_txn(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_at, input bit halt_mid,
                          input exp_t e, output int n_busy, output int n_stall);
        exp_t x;
        bit   seen;
        n_busy = 0; n_stall = 0; seen = 0;
        @(negedge clk);
        bus.valid_in = 1'b1; bus.opcode_in = op; bus.funct3_in = f3;
        bus.addr_in = addr; bus.wdata_in = wdata;
        sb_q.push_back(e);
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL %s accept_stall: got %b want 1", name, bus.stall);
        end
        if (bus.stall === 1'b1) n_stall++;
        @(negedge clk);
        bus.valid_in = 1'b0; bus.opcode_in = 7'd0;
        for (int c = 0; c < 40 && !seen; c++) begin
            if (bus.done || bus.err) begin
                seen = 1;
                x = sb_q.pop_front();
                checks++;
                if ({bus.done, bus.err} !== {~x.is_err, x.is_err}) begin
                    errors++;
                    $display("FAIL %s status: got done=%b err=%b want err=%b", name, bus.done, bus.err, x.is_err);
                end
                checks++;
                if (bus.rdata_out !== x.rdata) begin
                    errors++; $display("FAIL %s rdata: got %h want %h", name, bus.rdata_out, x.rdata);
                end
            end else if (bus.mem_req) begin
                n_busy++;
                if (bus.stall === 1'b1) n_stall++;
                checks++;
                if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata} !== {e.we, e.addr, e.be, e.wdata}) begin
                    errors++;
                    $display("FAIL %s bus: got we=%b addr=%h be=%b wdata=%h want we=%b addr=%h be=%b wdata=%h",
                             name, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata, e.we, e.addr, e.be, e.wdata);
                end
                if (halt_mid && n_busy == 1) bus.halt = 1'b1;
                if (n_busy == ack_at) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
                end
            end
            if (!seen) begin
                @(negedge clk);
                bus.mem_ack = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
            end
        end
        bus.halt = 1'b0;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s completion: got none within 40 cycles want done or err", name);
            void'(sb_q.pop_front());
        end else begin
            @(negedge clk);
            if ({bus.done, bus.err, bus.stall, bus.mem_req, bus.rdata_out} !== {4'b0000, x.rdata}) begin
                errors++;
                $display("FAIL %s after: got done=%b err=%b stall=%b req=%b rdata=%h want 0000 rdata=%h",
                         name, bus.done, bus.err, bus.stall, bus.mem_req, bus.rdata_out, x.rdata);
            end
        end
    endtask

    task automatic check_cnt(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++; $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        bus.halt = 1'b0; bus.valid_in = 1'b0; bus.opcode_in = 7'd0; bus.funct3_in = 3'd0;
        bus.addr_in = '0; bus.wdata_in = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
             bus.rdata_out, bus.done, bus.err, bus.stall} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b we=%b addr=%h be=%b wdata=%h rdata=%h done=%b err=%b stall=%b want all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                     bus.rdata_out, bus.done, bus.err, bus.stall);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_store();
        int nb, ns;
        do_txn("sb_lane2", c_op_store, 3'b000, 32'h1000_0006, 32'h0000_00A5, 32'h0, 2, 0,
               mk(0, 1, 32'h1000_0004, 4'b0100, 32'hA5A5_A5A5, 32'h0), nb, ns);
        check_cnt("sb_lane2 busy_cycles", nb, 2);
        check_cnt("sb_lane2 stall_cycles", ns, 3);
    endtask

    task automatic test_load();
        int nb, ns;
        do_txn("lb", c_op_load, 3'b000, 32'h0000_2003, 32'h0, 32'h80FF_1234, 1, 0,
               mk(0, 0, 32'h0000_2000, 4'b1000, 32'h0, 32'hFFFF_FF80), nb, ns);
        check_cnt("lb busy_cycles", nb, 1);
        do_txn("lbu", c_op_load, 3'b100, 32'h0000_2003, 32'h0, 32'h80FF_1234, 1, 0,
               mk(0, 0, 32'h0000_2000, 4'b1000, 32'h0, 32'h0000_0080), nb, ns);
        do_txn("lh_hi", c_op_load, 3'b001, 32'h0000_2002, 32'h0, 32'h80FF_1234, 2, 0,
               mk(0, 0, 32'h0000_2000, 4'b1100, 32'h0, 32'hFFFF_80FF), nb, ns);
        do_txn("lhu_lo", c_op_load, 3'b101, 32'h0000_2000, 32'h0, 32'h80FF_9234, 1, 0,
               mk(0, 0, 32'h0000_2000, 4'b0011, 32'h0, 32'h0000_9234), nb, ns);
        do_txn("lw", c_op_load, 3'b010, 32'h0000_2000, 32'h0, 32'h80FF_1234, 3, 0,
               mk(0, 0, 32'h0000_2000, 4'b1111, 32'h0, 32'h80FF_1234), nb, ns);
        do_txn("sh_hi", c_op_store, 3'b001, 32'h0000_2002, 32'hCAFE_BEEF, 32'h0, 1, 0,
               mk(0, 1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'h0), nb, ns);
    endtask

    task automatic test_misaligned();
        int nb, ns;
        do_txn("lh_odd", c_op_load, 3'b001, 32'h0000_2001, 32'h0, 32'h0, 1, 0,
               mk(1, 0, 32'h0, 4'b0, 32'h0, 32'h0), nb, ns);
        check_cnt("lh_odd busy_cycles", nb, 0);
        do_txn("lw_half", c_op_load, 3'b010, 32'h0000_2002, 32'h0, 32'h0, 1, 0,
               mk(1, 0, 32'h0, 4'b0, 32'h0, 32'h0), nb, ns);
        check_cnt("lw_half busy_cycles", nb, 0);
        do_txn("ld_f3_011", c_op_load, 3'b011, 32'h0000_2000, 32'h0, 32'h0, 1, 0,
               mk(1, 0, 32'h0, 4'b0, 32'h0, 32'h0), nb, ns);
        check_cnt("ld_f3_011 busy_cycles", nb, 0);
        do_txn("st_f3_100", c_op_store, 3'b100, 32'h0000_2000, 32'h55, 32'h0, 1, 0,
               mk(1, 0, 32'h0, 4'b0, 32'h0, 32'h0), nb, ns);
        check_cnt("st_f3_100 busy_cycles", nb, 0);
    endtask

    task automatic test_timeout();
        int nb, ns;
        do_txn("lw_timeout", c_op_load, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 0, 0,
               mk(1, 0, 32'h0000_3000, 4'b1111, 32'h0, 32'h0), nb, ns);
        check_cnt("lw_timeout req_cycles", nb, 15);
        do_txn("lw_ack_last", c_op_load, 3'b010, 32'h0000_3004, 32'h0, 32'h1357_9BDF, 15, 0,
               mk(0, 0, 32'h0000_3004, 4'b1111, 32'h0, 32'h1357_9BDF), nb, ns);
        check_cnt("lw_ack_last req_cycles", nb, 15);
    endtask

    task automatic test_halt();
        int  nb, ns;
        bit  bad;
        @(negedge clk);
        bus.halt = 1'b1; bus.valid_in = 1'b1; bus.opcode_in = c_op_load;
        bus.funct3_in = 3'b010; bus.addr_in = 32'h0000_4000;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL halt_stall: got %b want 0", bus.stall);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_req || bus.done || bus.err || bus.stall) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL halt_ignored: got activity=1 want 0");
        end
        bus.halt = 1'b0; bus.opcode_in = c_op_alu;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL alu_stall: got %b want 0", bus.stall);
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.mem_req || bus.done || bus.err || bus.stall) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL alu_ignored: got activity=1 want 0");
        end
        bus.valid_in = 1'b0; bus.opcode_in = 7'd0;
        do_txn("lw_halt_mid", c_op_load, 3'b010, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 3, 1,
               mk(0, 0, 32'h0000_4000, 4'b1111, 32'h0, 32'h0BAD_F00D), nb, ns);
        check_cnt("lw_halt_mid busy_cycles", nb, 3);
    endtask

    task automatic test_reset_mid_busy();
        int nb, ns;
        bit bad;
        @(negedge clk);
        bus.valid_in = 1'b1; bus.opcode_in = c_op_load; bus.funct3_in = 3'b010;
        bus.addr_in = 32'h0000_3000;
        @(negedge clk);
        bus.valid_in = 1'b0; bus.opcode_in = 7'd0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre_req: got %b want 1", bus.mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_req, bus.stall, bus.done, bus.err, bus.mem_be} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_async: got req=%b stall=%b done=%b err=%b be=%b want all 0",
                     bus.mem_req, bus.stall, bus.done, bus.err, bus.mem_be);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_req || bus.done || bus.err) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL rst_mid_abandon: got activity=1 want 0");
        end
        do_txn("sw_after_rst", c_op_store, 3'b010, 32'h0000_0010, 32'h1234_5678, 32'h0, 1, 0,
               mk(0, 1, 32'h0000_0010, 4'b1111, 32'h1234_5678, 32'h0), nb, ns);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store();
        test_load();
        test_misaligned();
        test_timeout();
        test_halt();
        test_reset_mid_busy();
        checks++;
        if (sb_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_empty: got %0d want 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
